// File: rtl/avalon_timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : avalon_timer_ctrl                                               |
// | Purpose  : Sequencing controller for the 32-bit Avalon-MM timer. Runs a    |
// |            prescaled down-counter (one-shot or periodic reload), writes    |
// |            the live count back to the slave's read-only register and       |
// |            raises a level interrupt on expiry.                             |
// | Ports    : clock    - system clock, rising edge                            |
// |            reset    - asynchronous active-high reset                       |
// |            ctrl     - [0] EN, [1] MODE (1 periodic), [2] IE, [3] IACK       |
// |            period   - reload value N (N+1 ticks per expiry)                |
// |            prescale - prescaler compare P, bits [PRESCALE_W-1:0]           |
// |            data     - count value for the slave's read-only register       |
// |            we       - one-cycle write strobe qualifying data               |
// |            status   - {flag, done, run}                                    |
// |            irq      - level interrupt, flag & IE                           |
// | Options  : AVALON_TIMER_CTRL_PRESCALER_EN builds the prescaler; without it |
// |            the counter ticks every RUN cycle and prescale is ignored.      |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module avalon_timer_ctrl #(
  parameter int PRESCALE_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ctrl,
  input  logic [31:0] period,
  input  logic [31:0] prescale,
  output logic [31:0] data,
  output logic        we,
  output logic [2:0]  status,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_count, w_count_nxt;
  logic [31:0] r_data;
  logic        r_we;
  logic        r_flag, w_flag_nxt;
  logic        r_en_q;
  logic        r_iack_q;
  logic        w_wr;
  logic        w_start;
  logic        w_stop;
  logic        w_tick;
  logic        w_pcnt_hit;
  logic        w_unused;

  // Only EN, MODE, IE and IACK are meaningful; the rest of ctrl and any
  // prescale bits above the compare field are deliberately ignored.
  assign w_unused = ^{ctrl[31:4], prescale};

`ifdef AVALON_TIMER_CTRL_PRESCALER_EN
  logic [PRESCALE_W-1:0] r_pcnt, w_pcnt_nxt;
  assign w_pcnt_hit = (r_pcnt == prescale[PRESCALE_W-1:0]);
`else
  logic [PRESCALE_W-1:0] w_unused_psc;
  assign w_unused_psc = prescale[PRESCALE_W-1:0];
  assign w_pcnt_hit   = 1'b1;
`endif

  // EN is level-sensitive for stop but edge-sensitive for start, so an EN held
  // high after a one-shot completes does not retrigger the timer.
  assign w_start = ctrl[0] & ~r_en_q & (r_state != RUN);
  assign w_stop  = ~ctrl[0] & (r_state == RUN);
  assign w_tick  = (r_state == RUN) & ~w_stop & w_pcnt_hit;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_flag_nxt  = r_flag;
    w_wr        = 1'b0;
`ifdef AVALON_TIMER_CTRL_PRESCALER_EN
    w_pcnt_nxt  = r_pcnt;
`endif

    // IACK edge clears first so that a coincident expiry below overrides it.
    if (ctrl[3] && !r_iack_q) begin
      w_flag_nxt = 1'b0;
    end

    case (r_state)
      IDLE, DONE: begin
        if (w_start) begin
          w_state_nxt = RUN;
          w_count_nxt = period;
          w_wr        = 1'b1;
`ifdef AVALON_TIMER_CTRL_PRESCALER_EN
          w_pcnt_nxt  = '0;
`endif
        end
      end
      RUN: begin
        if (w_stop) begin
          w_state_nxt = IDLE;
        end else if (w_tick) begin
`ifdef AVALON_TIMER_CTRL_PRESCALER_EN
          w_pcnt_nxt = '0;
`endif
          if (r_count != 32'd0) begin
            w_count_nxt = r_count - 32'd1;
            w_wr        = 1'b1;
          end else begin
            // Expiry: zero is terminal, so the decrement can never wrap.
            w_flag_nxt = 1'b1;
            if (ctrl[1]) begin
              w_count_nxt = period;
              w_wr        = 1'b1;
            end else begin
              w_state_nxt = DONE;
            end
          end
        end else begin
`ifdef AVALON_TIMER_CTRL_PRESCALER_EN
          w_pcnt_nxt = r_pcnt + 1'b1;
`endif
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= 32'd0;
      r_data   <= 32'd0;
      r_we     <= 1'b0;
      r_flag   <= 1'b0;
      r_en_q   <= 1'b0;
      r_iack_q <= 1'b0;
`ifdef AVALON_TIMER_CTRL_PRESCALER_EN
      r_pcnt   <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_flag   <= w_flag_nxt;
      r_en_q   <= ctrl[0];
      r_iack_q <= ctrl[3];
      r_we     <= w_wr;
      if (w_wr) begin
        r_data <= w_count_nxt;
      end
`ifdef AVALON_TIMER_CTRL_PRESCALER_EN
      r_pcnt   <= w_pcnt_nxt;
`endif
    end
  end

  assign data   = r_data;
  assign we     = r_we;
  assign status = {r_flag, (r_state == DONE), (r_state == RUN)};
  assign irq    = r_flag & ctrl[2];

endmodule
`default_nettype wire
